frost32_mem_responder: RTL and testbench
========================================

# frost32_mem_responder

Memory-side responder for the Frost32 CPU data port: it accepts the CPU's memory access requests (address, data, read/write type, 32/16/8-bit size, request strobe), performs them against an internal little-endian word RAM after a configurable number of wait cycles, and drives back read data and `wait_for_mem`. It sits between the CPU's `PortOut_Frost32Cpu` memory-access members and the `PortIn_Frost32Cpu` `data`/`wait_for_mem` inputs, and is the standard memory model for system builds and CPU benches.

## Interface
- `DEPTH_WORDS`, 16384, number of 32-bit RAM words; must be a power of two.
- `LATENCY`, 2, number of Busy cycles per access; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock domain, synchronous, active-high.
- `in_req_mem_access`  in  1  CPU request strobe.
- `in_addr`  in  32  byte address.
- `in_data`  in  32  write data, right-justified for 16/8-bit stores.
- `in_data_inout_access_type`  in  1  0 = DiatRead, 1 = DiatWrite.
- `in_data_inout_access_size`  in  2  0 = Dias32, 1 = Dias16, 2 = Dias8, 3 = DiasBad.
- `out_data`  out  32  read data to CPU `data`.
- `out_wait_for_mem`  out  1  to CPU `wait_for_mem`.
- `out_bus_error`  out  1  one-cycle pulse marking a rejected access.

## Operation
- States: StIdle, StBusy, StDone. Reset state StIdle.
- StIdle: if `in_req_mem_access`=1, latch addr, data, type, size into request registers, load busy counter with LATENCY, go StBusy. Otherwise stay.
- StBusy: decrement counter; when counter reaches 1, perform the access at that edge and go StDone.
- StDone: one cycle; `in_req_mem_access` ignored; go StIdle.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2]; any set bit in addr[31:log2(DEPTH_WORDS)+2] is out of range.
- Error conditions: size DiasBad; Dias32 with addr[1:0]≠0; Dias16 with addr[0]≠0; out of range. On error: no RAM write, `out_data` loaded with 0, `out_bus_error`=1 during StDone.
- Writes, little-endian byte lanes: Dias32 writes all four bytes; Dias16 writes in_data[15:0] to bytes addr[1]*2 .. addr[1]*2+1; Dias8 writes in_data[7:0] to byte addr[1:0]. Other bytes unchanged. `out_data` unchanged on writes.
- Reads: selected bytes returned right-justified, zero-extended (sign extension is the CPU's job); Dias32 returns whole word.
- RAM contents are not reset; only control state and `out_data` are.

## Timing
- `out_wait_for_mem` = (StIdle & `in_req_mem_access`) | StBusy — combinational, so the CPU sees wait asserted in the same cycle it raises its request.
- Request seen in cycle T (StIdle): wait high cycles T..T+LATENCY; StDone in cycle T+LATENCY+1 with wait=0, `out_data` valid, `out_bus_error` valid.
- Next request accepted earliest at T+LATENCY+2; minimum access period LATENCY+2 cycles.
- `out_data` is registered and holds its value until the next completed read or reset.
- Read-after-write to the same address in back-to-back accesses returns the new data.
- Request inputs change during StBusy/StDone: ignored (latched copy used).
- Reset values: state StIdle, `out_data`=0, `out_wait_for_mem`=0 (when req low), `out_bus_error`=0, counter 0.
- `rst` during StBusy: access aborted, no RAM write, StIdle next cycle.
- `rst` and `in_req_mem_access` in the same cycle: reset wins, request not latched.

## Test plan
- Reset, then write Dias32 0xDEADBEEF to 0x10, read Dias32 from 0x10 -> wait high for 1+LATENCY cycles each, read `out_data`=0xDEADBEEF in StDone, `out_bus_error`=0.
- After above, Dias8 write 0x5A to 0x12, Dias16 read 0x12 -> 0x0000DE5A; Dias8 read 0x13 -> 0x000000DE; Dias32 read 0x10 -> 0xDE5ABEEF.
- Dias32 read at 0x11, Dias16 write at 0x13, DiasBad read, read at byte 4*DEPTH_WORDS -> each asserts `out_bus_error` for exactly one cycle, `out_data`=0, RAM unchanged.
- Hold `in_req_mem_access` high continuously with new addresses each access -> one access per LATENCY+2 cycles, request in StDone cycle not accepted, addresses changed during StBusy not used.
- Assert `rst` mid-StBusy of a write of 0x12345678 to 0x20 -> wait drops, StIdle next cycle, later read of 0x20 returns prior contents.
- Sweep LATENCY=1 and LATENCY=15 -> wait high for exactly 2 and 16 cycles per access.

Source files
------------

// File: rtl/frost32_mem_responder.sv
// Memory-side responder for the Frost32 CPU data port: latches one request,
// waits LATENCY busy cycles, then performs it against a little-endian word RAM.
module frost32_mem_responder #(
   parameter int DEPTH_WORDS = 16384,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_req_mem_access,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic        in_data_inout_access_type,
   input  logic [1:0]  in_data_inout_access_size,
   output logic [31:0] out_data,
   output logic        out_wait_for_mem,
   output logic        out_bus_error
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] HI_MASK = ~((32'd1 << (AW + 2)) - 32'd1);
   localparam logic [3:0]  LAT     = 4'(LATENCY);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] SZ_32  = 2'd0;
   localparam logic [1:0] SZ_16  = 2'd1;
   localparam logic [1:0] SZ_8   = 2'd2;
   localparam logic [1:0] SZ_BAD = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] outData_q, outData_d;
   logic        busErr_q, busErr_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] wordIdx;
   logic          accErr;
   logic          fire;
   logic          memWe;
   logic [3:0]    byteEn;
   logic [31:0]   laneData;
   logic [31:0]   rdWord;
   logic [31:0]   rdSel;

   assign wordIdx = addr_q[AW+1:2];
   assign fire    = (state_q == ST_BUSY) && (cnt_q == 4'd1);
   assign rdWord  = mem[wordIdx];

   assign accErr = (size_q == SZ_BAD)
                || ((size_q == SZ_32) && (addr_q[1:0] != 2'b00))
                || ((size_q == SZ_16) && addr_q[0])
                || ((addr_q & HI_MASK) != 32'd0);

   assign memWe = fire && !accErr && wr_q && !rst;

   // Narrow stores are replicated across all lanes so the byte enables alone pick the target bytes.
   always_comb begin
      byteEn   = 4'b0000;
      laneData = wdata_q;
      case (size_q)
         SZ_32: byteEn = 4'b1111;
         SZ_16: begin
            byteEn   = addr_q[1] ? 4'b1100 : 4'b0011;
            laneData = {2{wdata_q[15:0]}};
         end
         SZ_8: begin
            byteEn   = 4'b0001 << addr_q[1:0];
            laneData = {4{wdata_q[7:0]}};
         end
         default: byteEn = 4'b0000;
      endcase
   end

   always_comb begin
      rdSel = 32'd0;
      case (size_q)
         SZ_32: rdSel = rdWord;
         SZ_16: rdSel = addr_q[1] ? {16'd0, rdWord[31:16]} : {16'd0, rdWord[15:0]};
         SZ_8: begin
            case (addr_q[1:0])
               2'd0:    rdSel = {24'd0, rdWord[7:0]};
               2'd1:    rdSel = {24'd0, rdWord[15:8]};
               2'd2:    rdSel = {24'd0, rdWord[23:16]};
               default: rdSel = {24'd0, rdWord[31:24]};
            endcase
         end
         default: rdSel = 32'd0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      size_d    = size_q;
      outData_d = outData_q;
      busErr_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_req_mem_access) begin
               addr_d  = in_addr;
               wdata_d = in_data;
               wr_d    = in_data_inout_access_type;
               size_d  = in_data_inout_access_size;
               cnt_d   = LAT;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (fire) begin
               state_d = ST_DONE;
               cnt_d   = 4'd0;
               if (accErr) begin
                  outData_d = 32'd0;
                  busErr_d  = 1'b1;
               end else if (!wr_q) begin
                  outData_d = rdSel;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wr_q      <= 1'b0;
         size_q    <= SZ_32;
         outData_q <= 32'd0;
         busErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         outData_q <= outData_d;
         busErr_q  <= busErr_d;
      end
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
         end
      end
   end

   assign out_wait_for_mem = ((state_q == ST_IDLE) && in_req_mem_access) || (state_q == ST_BUSY);
   assign out_data         = outData_q;
   assign out_bus_error    = busErr_q;

endmodule

// File: tb/tb_frost32_mem_responder.sv
// Randomised and directed bench for frost32_mem_responder, checked against a
// byte-addressed reference memory model.
module tb_frost32_mem_responder;

   localparam int MAIN_DEPTH = 16384;
   localparam int MAIN_LAT   = 2;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] expData;
      logic        expErr;
   } op_t;

   logic        clk;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic [31:0] dataIn;
   logic        accType;
   logic [1:0]  accSize;
   int          sel;

   logic        reqMain, req1, req15;
   logic [31:0] dMain, d1, d15;
   logic        wMain, w1, w15;
   logic        eMain, e1, e15;
   logic [31:0] muxData;
   logic        muxWait;
   logic        muxBerr;

   int passCount;
   int checkCount;

   logic [7:0]  refMem [logic [31:0]];
   logic [31:0] refLast;

   assign reqMain = req && (sel == 0);
   assign req1    = req && (sel == 1);
   assign req15   = req && (sel == 2);

   frost32_mem_responder #(.DEPTH_WORDS(MAIN_DEPTH), .LATENCY(MAIN_LAT)) uMain (
      .clk(clk), .rst(rst), .in_req_mem_access(reqMain), .in_addr(addr), .in_data(dataIn),
      .in_data_inout_access_type(accType), .in_data_inout_access_size(accSize),
      .out_data(dMain), .out_wait_for_mem(wMain), .out_bus_error(eMain));

   frost32_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) uLat1 (
      .clk(clk), .rst(rst), .in_req_mem_access(req1), .in_addr(addr), .in_data(dataIn),
      .in_data_inout_access_type(accType), .in_data_inout_access_size(accSize),
      .out_data(d1), .out_wait_for_mem(w1), .out_bus_error(e1));

   frost32_mem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) uLat15 (
      .clk(clk), .rst(rst), .in_req_mem_access(req15), .in_addr(addr), .in_data(dataIn),
      .in_data_inout_access_type(accType), .in_data_inout_access_size(accSize),
      .out_data(d15), .out_wait_for_mem(w15), .out_bus_error(e15));

   always_comb begin
      muxData = dMain;
      muxWait = wMain;
      muxBerr = eMain;
      if (sel == 1) begin
         muxData = d1;
         muxWait = w1;
         muxBerr = e1;
      end else if (sel == 2) begin
         muxData = d15;
         muxWait = w15;
         muxBerr = e15;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: byte-addressed memory, result register of the main instance.
   function automatic void refAccess(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                     input logic [31:0] d, output logic err, output logic [31:0] dOut);
      int n;
      logic [31:0] v;
      n   = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
      err = (sz == 2'd3) || ((a & 32'(n - 1)) != 32'd0) || (a >= 32'(4 * MAIN_DEPTH));
      if (err) begin
         refLast = 32'd0;
      end else if (wr) begin
         for (int i = 0; i < n; i++) refMem[a + 32'(i)] = d[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(refMem[a + 32'(i)]) << (8 * i));
         refLast = v;
      end
      dOut = refLast;
   endfunction

   // One full access; request inputs are scrambled once the request has been taken.
   task automatic doAccess(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           output int waits, output logic [31:0] rdata, output logic berr, output logic berrAfter);
      int guard;
      @(negedge clk);
      req = 1'b1; addr = a; dataIn = d; accType = wr; accSize = sz;
      waits = 0;
      guard = 0;
      #1;
      while (muxWait === 1'b1 && guard < 40) begin
         waits++;
         guard++;
         @(negedge clk);
         req = 1'b0; addr = $urandom; dataIn = $urandom; accType = 1'($urandom); accSize = 2'($urandom);
         #1;
      end
      rdata = muxData;
      berr  = muxBerr;
      @(negedge clk);
      #1;
      berrAfter = muxBerr;
   endtask

   task automatic test_reset();
      sel = 0; req = 1'b0; rst = 1'b1;
      addr = 32'd0; dataIn = 32'd0; accType = 1'b0; accSize = 2'd0;
      repeat (3) @(negedge clk);
      #1;
      checkCount++;
      if (muxWait !== 1'b0) $display("[TB] FAIL reset_wait got %b want 0", muxWait); else passCount++;
      checkCount++;
      if (muxData !== 32'd0) $display("[TB] FAIL reset_data got %h want 0", muxData); else passCount++;
      checkCount++;
      if (muxBerr !== 1'b0) $display("[TB] FAIL reset_berr got %b want 0", muxBerr); else passCount++;
      rst = 1'b0;
      refLast = 32'd0;
   endtask

   task automatic test_basic();
      op_t ops[$];
      int waits;
      logic [31:0] rd, md;
      logic be, ba, me;
      ops.push_back(op_t'{1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
      ops.push_back(op_t'{1'b1, 2'd2, 32'h12, 32'h5A,       32'hDEADBEEF, 1'b0});
      ops.push_back(op_t'{1'b0, 2'd1, 32'h12, 32'h0,        32'h0000DE5A, 1'b0});
      ops.push_back(op_t'{1'b0, 2'd2, 32'h13, 32'h0,        32'h000000DE, 1'b0});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10, 32'h0,        32'hDE5ABEEF, 1'b0});
      sel = 0;
      foreach (ops[i]) begin
         doAccess(ops[i].wr, ops[i].sz, ops[i].a, ops[i].d, waits, rd, be, ba);
         refAccess(ops[i].wr, ops[i].sz, ops[i].a, ops[i].d, me, md);
         checkCount++;
         if (waits != MAIN_LAT + 1) $display("[TB] FAIL basic_waits op%0d got %0d want %0d", i, waits, MAIN_LAT + 1); else passCount++;
         checkCount++;
         if (rd !== ops[i].expData) $display("[TB] FAIL basic_data op%0d got %h want %h", i, rd, ops[i].expData); else passCount++;
         checkCount++;
         if (be !== ops[i].expErr) $display("[TB] FAIL basic_berr op%0d got %b want %b", i, be, ops[i].expErr); else passCount++;
      end
   endtask

   task automatic test_errors();
      op_t ops[$];
      int waits;
      logic [31:0] rd, md;
      logic be, ba, me;
      ops.push_back(op_t'{1'b0, 2'd0, 32'h11,    32'h0,        32'h0,        1'b1});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10,    32'h0,        32'hDE5ABEEF, 1'b0});
      ops.push_back(op_t'{1'b1, 2'd1, 32'h13,    32'hAAAA,     32'h0,        1'b1});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10,    32'h0,        32'hDE5ABEEF, 1'b0});
      ops.push_back(op_t'{1'b0, 2'd3, 32'h10,    32'h0,        32'h0,        1'b1});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10,    32'h0,        32'hDE5ABEEF, 1'b0});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10000, 32'h0,        32'h0,        1'b1});
      ops.push_back(op_t'{1'b1, 2'd0, 32'h10010, 32'hFFFFFFFF, 32'h0,        1'b1});
      ops.push_back(op_t'{1'b0, 2'd0, 32'h10,    32'h0,        32'hDE5ABEEF, 1'b0});
      sel = 0;
      foreach (ops[i]) begin
         doAccess(ops[i].wr, ops[i].sz, ops[i].a, ops[i].d, waits, rd, be, ba);
         refAccess(ops[i].wr, ops[i].sz, ops[i].a, ops[i].d, me, md);
         checkCount++;
         if (waits != MAIN_LAT + 1) $display("[TB] FAIL err_waits op%0d got %0d want %0d", i, waits, MAIN_LAT + 1); else passCount++;
         checkCount++;
         if (rd !== ops[i].expData) $display("[TB] FAIL err_data op%0d got %h want %h", i, rd, ops[i].expData); else passCount++;
         checkCount++;
         if (be !== ops[i].expErr) $display("[TB] FAIL err_berr op%0d got %b want %b", i, be, ops[i].expErr); else passCount++;
         checkCount++;
         if (ba !== 1'b0) $display("[TB] FAIL err_pulse op%0d got %b want 0", i, ba); else passCount++;
      end
   endtask

   task automatic test_random();
      int waits;
      logic [31:0] rd, md, a, d;
      logic be, ba, me, wr;
      logic [1:0] sz;
      sel = 0;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         doAccess(1'b1, 2'd0, 32'h100 + 32'(4 * i), d, waits, rd, be, ba);
         refAccess(1'b1, 2'd0, 32'h100 + 32'(4 * i), d, me, md);
      end
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(1, 0));
         sz = 2'($urandom_range(3, 0));
         a  = 32'h100 + 32'($urandom_range(63, 0));
         if ($urandom_range(7, 0) == 0) a = 32'h10000 + 32'($urandom_range(255, 0));
         d  = $urandom;
         doAccess(wr, sz, a, d, waits, rd, be, ba);
         refAccess(wr, sz, a, d, me, md);
         checkCount++;
         if (waits != MAIN_LAT + 1) $display("[TB] FAIL rand_waits op%0d got %0d want %0d", i, waits, MAIN_LAT + 1); else passCount++;
         checkCount++;
         if (rd !== md) $display("[TB] FAIL rand_data op%0d a=%h sz=%0d wr=%b got %h want %h", i, a, sz, wr, rd, md); else passCount++;
         checkCount++;
         if (be !== me) $display("[TB] FAIL rand_berr op%0d got %b want %b", i, be, me); else passCount++;
         checkCount++;
         if (ba !== 1'b0) $display("[TB] FAIL rand_pulse op%0d got %b want 0", i, ba); else passCount++;
      end
   endtask

   // Request held high throughout; idle cycles get a fresh address, all other cycles get junk.
   task automatic test_back_to_back();
      logic [31:0] addrs[6];
      logic [31:0] md;
      logic me, nextIdle;
      int k, lastDone, limit;
      sel = 0;
      for (int i = 0; i < 6; i++) addrs[i] = 32'h100 + 32'(4 * $urandom_range(15, 0));
      k = 0;
      lastDone = -1;
      limit = 6 * (MAIN_LAT + 2) + 10;
      @(negedge clk);
      req = 1'b1; addr = addrs[0]; accType = 1'b0; accSize = 2'd0; dataIn = $urandom;
      for (int c = 0; c < limit && k < 6; c++) begin
         #1;
         nextIdle = 1'b0;
         if (muxWait === 1'b0) begin
            refAccess(1'b0, 2'd0, addrs[k], 32'd0, me, md);
            checkCount++;
            if (muxData !== md) $display("[TB] FAIL b2b_data acc%0d got %h want %h", k, muxData, md); else passCount++;
            checkCount++;
            if (muxBerr !== 1'b0) $display("[TB] FAIL b2b_berr acc%0d got %b want 0", k, muxBerr); else passCount++;
            if (lastDone >= 0) begin
               checkCount++;
               if (c - lastDone != MAIN_LAT + 2) $display("[TB] FAIL b2b_period acc%0d got %0d want %0d", k, c - lastDone, MAIN_LAT + 2); else passCount++;
            end
            lastDone = c;
            k++;
            nextIdle = 1'b1;
         end
         @(negedge clk);
         if (k >= 6) begin
            req = 1'b0;
         end else if (nextIdle) begin
            addr = addrs[k]; accSize = 2'd0; accType = 1'b0;
         end else begin
            addr = 32'hFFFF_FFF0; accSize = 2'($urandom); accType = 1'($urandom); dataIn = $urandom;
         end
      end
      req = 1'b0;
      checkCount++;
      if (k != 6) $display("[TB] FAIL b2b_timeout got %0d accesses want 6", k); else passCount++;
   endtask

   task automatic test_reset_abort();
      int waits;
      logic [31:0] rd, md;
      logic be, ba, me;
      sel = 0;
      doAccess(1'b1, 2'd0, 32'h20, 32'hA5A5A5A5, waits, rd, be, ba);
      refAccess(1'b1, 2'd0, 32'h20, 32'hA5A5A5A5, me, md);
      @(negedge clk);
      req = 1'b1; addr = 32'h20; dataIn = 32'h12345678; accType = 1'b1; accSize = 2'd0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkCount++;
      if (muxWait !== 1'b0) $display("[TB] FAIL abort_wait got %b want 0", muxWait); else passCount++;
      checkCount++;
      if (muxData !== 32'd0) $display("[TB] FAIL abort_data got %h want 0", muxData); else passCount++;
      rst = 1'b0;
      refLast = 32'd0;
      @(negedge clk);
      rst = 1'b1; req = 1'b1; addr = 32'h20; dataIn = 32'h0BADF00D; accType = 1'b1; accSize = 2'd0;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      #1;
      checkCount++;
      if (muxWait !== 1'b0) $display("[TB] FAIL rstreq_wait got %b want 0", muxWait); else passCount++;
      doAccess(1'b0, 2'd0, 32'h20, 32'd0, waits, rd, be, ba);
      refAccess(1'b0, 2'd0, 32'h20, 32'd0, me, md);
      checkCount++;
      if (rd !== 32'hA5A5A5A5) $display("[TB] FAIL abort_ram got %h want A5A5A5A5", rd); else passCount++;
   endtask

   task automatic test_latency_sweep();
      int waits, lat;
      logic [31:0] rd, d;
      logic be, ba;
      for (int s = 1; s <= 2; s++) begin
         sel = s;
         lat = (s == 1) ? 1 : 15;
         d = $urandom;
         doAccess(1'b1, 2'd0, 32'h8, d, waits, rd, be, ba);
         checkCount++;
         if (waits != lat + 1) $display("[TB] FAIL sweep_wwaits lat%0d got %0d want %0d", lat, waits, lat + 1); else passCount++;
         doAccess(1'b0, 2'd0, 32'h8, 32'd0, waits, rd, be, ba);
         checkCount++;
         if (waits != lat + 1) $display("[TB] FAIL sweep_rwaits lat%0d got %0d want %0d", lat, waits, lat + 1); else passCount++;
         checkCount++;
         if (rd !== d) $display("[TB] FAIL sweep_data lat%0d got %h want %h", lat, rd, d); else passCount++;
      end
      sel = 0;
   endtask

   initial begin
      passCount = 0;
      checkCount = 0;
      test_reset();
      test_basic();
      test_errors();
      test_random();
      test_back_to_back();
      test_reset_abort();
      test_latency_sweep();
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
